// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the wristwatch countdown-timer mode: FSM state
// encoding and BCD digit limits.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        CD_SET   = 2'd0,
        CD_RUN   = 2'd1,
        CD_PAUSE = 2'd2,
        CD_ALARM = 2'd3
    } cd_state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/cd_bcd_digit.sv
// One BCD digit register with clear, parallel load, increment (wrapping at
// i_max) and decrement (wrapping 0 -> i_max and raising a borrow to the next digit).
module cd_bcd_digit (
    input  logic       uclock,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [3:0] i_loadVal,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic [3:0] i_max,
    output logic [3:0] o_digit,
    output logic       o_borrow
);

    logic [3:0] r_digit;

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            r_digit <= 4'd0;
        end else if (i_clear) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= i_loadVal;
        end else if (i_dec) begin
            r_digit <= (r_digit == 4'd0) ? i_max : r_digit - 4'd1;
        end else if (i_inc) begin
            r_digit <= (r_digit == i_max) ? 4'd0 : r_digit + 4'd1;
        end
    end

    // Borrow is combinational so a whole MM:SS decrement ripples in one cycle.
    assign o_borrow = i_dec && (r_digit == 4'd0);
    assign o_digit  = r_digit;

endmodule

// File: rtl/countdown_timer.sv
// Countdown-timer mode: MM:SS BCD preset, 1 Hz countdown, pause, and a
// self-terminating buzzer alarm on expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int BUZZ_DIV   = 25000,
    parameter int ALARM_SECS = 30
) (
    input  logic       uclock,
    input  logic       reset,
    input  logic       tick,
    input  logic       cdswitch,
    input  logic       b_start,
    input  logic       b_clear,
    input  logic       b_min,
    input  logic       b_sec,
    output logic [3:0] cd3,
    output logic [3:0] cd2,
    output logic [3:0] cd1,
    output logic [3:0] cd0,
    output logic       buzzer2,
    output logic       running,
    output logic       alarm
);

    localparam int DIV_W  = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam int TICK_W = $clog2(ALARM_SECS + 1);

    cd_state_t r_state;
    cd_state_t w_nextState;

    logic [15:0]       r_preset;
    logic              r_startQ, r_clearQ, r_minQ, r_secQ;
    logic [DIV_W-1:0]  r_buzzDiv;
    logic [TICK_W-1:0] r_alarmTicks;
    logic              r_tone;
    logic              r_buzzer2;

    logic        w_pStart, w_pClear, w_pMin, w_pSec, w_anyPress;
    logic [3:0]  w_d3, w_d2, w_d1, w_d0;
    logic [15:0] w_digits;
    logic        w_isZero, w_isOne;
    logic        w_clear, w_load, w_dec, w_secInc, w_minInc, w_capture;
    logic        w_borrow0, w_borrow1, w_borrow2, w_unusedBorrow3;
    logic        w_inAlarm, w_divWrap, w_timeout, w_toneNext;

    // Edge registers follow the buttons even when the mode is disabled, so
    // re-enabling with a button already held does not look like a press.
    assign w_pStart   = cdswitch && b_start && !r_startQ;
    assign w_pClear   = cdswitch && b_clear && !r_clearQ;
    assign w_pMin     = cdswitch && b_min   && !r_minQ;
    assign w_pSec     = cdswitch && b_sec   && !r_secQ;
    assign w_anyPress = w_pStart || w_pClear || w_pMin || w_pSec;

    assign w_digits  = {w_d3, w_d2, w_d1, w_d0};
    assign w_isZero  = (w_digits == 16'h0000);
    assign w_isOne   = (w_digits == 16'h0001);
    assign w_divWrap = (r_buzzDiv == DIV_W'(BUZZ_DIV - 1));
    assign w_timeout = tick && (r_alarmTicks == TICK_W'(ALARM_SECS - 1));

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            r_state <= CD_SET;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_secInc    = 1'b0;
        w_minInc    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            CD_SET: begin
                if (w_pClear) begin
                    w_clear = 1'b1;
                end else if (w_pStart && !w_isZero) begin
                    w_capture   = 1'b1;
                    w_nextState = CD_RUN;
                end else begin
                    w_secInc = w_pSec;
                    w_minInc = w_pMin;
                end
            end
            CD_RUN: begin
                // A start press wins over a coincident tick; that tick is lost.
                if (w_pStart) begin
                    w_nextState = CD_PAUSE;
                end else if (tick) begin
                    w_dec = 1'b1;
                    if (w_isOne) begin
                        w_nextState = CD_ALARM;
                    end
                end
            end
            CD_PAUSE: begin
                if (w_pStart) begin
                    w_nextState = CD_RUN;
                end else if (w_pClear) begin
                    w_clear     = 1'b1;
                    w_nextState = CD_SET;
                end
            end
            CD_ALARM: begin
                if (w_anyPress || w_timeout) begin
                    w_load      = 1'b1;
                    w_nextState = CD_SET;
                end
            end
            default: w_nextState = CD_SET;
        endcase
    end

    // Counters only advance while staying in ALARM, so entry starts them at zero.
    assign w_inAlarm  = (r_state == CD_ALARM) && (w_nextState == CD_ALARM);
    assign w_toneNext = w_inAlarm && (r_tone ^ w_divWrap);

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            r_preset     <= 16'h0000;
            r_startQ     <= 1'b0;
            r_clearQ     <= 1'b0;
            r_minQ       <= 1'b0;
            r_secQ       <= 1'b0;
            r_buzzDiv    <= '0;
            r_alarmTicks <= '0;
            r_tone       <= 1'b0;
            r_buzzer2    <= 1'b0;
        end else begin
            r_startQ <= b_start;
            r_clearQ <= b_clear;
            r_minQ   <= b_min;
            r_secQ   <= b_sec;
            if (w_capture) begin
                r_preset <= w_digits;
            end
            if (!w_inAlarm) begin
                r_buzzDiv    <= '0;
                r_alarmTicks <= '0;
            end else begin
                r_buzzDiv <= w_divWrap ? '0 : r_buzzDiv + DIV_W'(1);
                if (tick) begin
                    r_alarmTicks <= r_alarmTicks + TICK_W'(1);
                end
            end
            r_tone    <= w_toneNext;
            r_buzzer2 <= w_toneNext && cdswitch;
        end
    end

    cd_bcd_digit u_digit0 (
        .uclock(uclock), .reset(reset), .i_clear(w_clear), .i_load(w_load),
        .i_loadVal(r_preset[3:0]), .i_inc(w_secInc), .i_dec(w_dec),
        .i_max(DIGIT_MAX), .o_digit(w_d0), .o_borrow(w_borrow0)
    );

    cd_bcd_digit u_digit1 (
        .uclock(uclock), .reset(reset), .i_clear(w_clear), .i_load(w_load),
        .i_loadVal(r_preset[7:4]), .i_inc(w_secInc && (w_d0 == DIGIT_MAX)),
        .i_dec(w_borrow0), .i_max(SEC_TENS_MAX), .o_digit(w_d1), .o_borrow(w_borrow1)
    );

    cd_bcd_digit u_digit2 (
        .uclock(uclock), .reset(reset), .i_clear(w_clear), .i_load(w_load),
        .i_loadVal(r_preset[11:8]), .i_inc(w_minInc), .i_dec(w_borrow1),
        .i_max(DIGIT_MAX), .o_digit(w_d2), .o_borrow(w_borrow2)
    );

    // The top digit's borrow can never fire: RUN always leaves at 00:00.
    cd_bcd_digit u_digit3 (
        .uclock(uclock), .reset(reset), .i_clear(w_clear), .i_load(w_load),
        .i_loadVal(r_preset[15:12]), .i_inc(w_minInc && (w_d2 == DIGIT_MAX)),
        .i_dec(w_borrow2), .i_max(DIGIT_MAX), .o_digit(w_d3), .o_borrow(w_unusedBorrow3)
    );

    assign cd3     = w_d3;
    assign cd2     = w_d2;
    assign cd1     = w_d1;
    assign cd0     = w_d0;
    assign buzzer2 = r_buzzer2;
    assign running = (r_state == CD_RUN);
    assign alarm   = (r_state == CD_ALARM);

endmodule
